// File: rtl/bus_arb_pkg.sv
// Shared definitions for the bus requester and its arbiter-facing logic:
// FSM state encoding and default payload/FIFO sizing.
package bus_arb_pkg;

  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned DEPTH_DEF  = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_XFER = 2'd2,
    ST_REL  = 2'd3
  } req_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO. Pointers carry one extra wrap bit so full and
// empty are told apart without a separate counter. The head word is read
// combinationally so a granted bus sees the beat in the same cycle.
module sync_fifo #(
  parameter int unsigned WIDTH = 9,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [AW:0]      level_o
);

  localparam int unsigned PW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic             push_ok;
  logic             pop_ok;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign level_o = wr_ptr_q - rd_ptr_q;
  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

  // Never overwrite a full FIFO or underflow an empty one.
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  // Storage array: written only, no reset needed on payload.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
    end
  end

  // Pointer update; wrap bit rolls naturally modulo 2*DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PW'(1);
    end
  end

endmodule

// File: rtl/bus_requester.sv
// Buffers upstream beats, requests the shared bus from a round-robin arbiter
// once a whole packet (or a full FIFO) is queued, and streams the burst while
// the grant holds. A grant lost mid-burst is flagged on a sticky err.
module bus_requester
  import bus_arb_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned DEPTH  = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_last,
  output logic              req,
  input  logic              gnt,
  output logic              bus_valid,
  output logic [DATA_W-1:0] bus_data,
  output logic              bus_last,
  input  logic              bus_ready,
  output logic              err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  req_state_e      state_q, state_d;
  logic            forced_q, forced_d;
  logic            err_q, err_d;
  logic [CW-1:0]   pkt_cnt_q, pkt_cnt_d;

  logic [DATA_W:0] fifo_head;
  logic            fifo_full;
  logic            fifo_empty;
  logic [AW:0]     fifo_level;
  logic            head_last;
  logic            push;
  logic            pop;
  logic            cnt_inc;
  logic            cnt_dec;

  assign wr_ready  = ~fifo_full;
  assign push      = wr_valid & ~fifo_full;
  assign pop       = bus_valid & bus_ready;
  assign head_last = fifo_head[DATA_W];
  assign bus_data  = fifo_head[DATA_W-1:0];
  assign err       = err_q;

  // The counter tracks stored last flags, so a forced burst ending on a
  // non-last beat does not decrement a count it never incremented.
  assign cnt_inc = push & wr_last;
  assign cnt_dec = pop & head_last;

  sync_fifo #(
    .WIDTH (DATA_W + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst),
    .push_i      (push),
    .push_data_i ({wr_last, wr_data}),
    .pop_i       (pop),
    .head_o      (fifo_head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .level_o     (fifo_level)
  );

  // Complete-packet count: simultaneous in/out events cancel.
  always_comb begin
    pkt_cnt_d = pkt_cnt_q;
    if (cnt_inc && !cnt_dec) begin
      pkt_cnt_d = pkt_cnt_q + CW'(1);
    end else if (!cnt_inc && cnt_dec) begin
      pkt_cnt_d = pkt_cnt_q - CW'(1);
    end
  end

  // Request/transfer FSM: next state plus decoded req and bus outputs.
  always_comb begin
    state_d   = state_q;
    forced_d  = forced_q;
    err_d     = err_q;
    req       = 1'b0;
    bus_valid = 1'b0;
    bus_last  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pkt_cnt_q != '0 || fifo_full) begin
          state_d  = ST_REQ;
          // Full with no complete packet: drain anyway to avoid deadlock.
          forced_d = (pkt_cnt_q == '0);
        end
      end
      ST_REQ: begin
        req = 1'b1;
        if (gnt) state_d = ST_XFER;
      end
      ST_XFER: begin
        req = 1'b1;
        if (!gnt) begin
          err_d   = 1'b1;
          state_d = ST_REL;
        end else begin
          bus_valid = ~fifo_empty;
          bus_last  = bus_valid &
                      (head_last | (forced_q && fifo_level == (AW+1)'(1)));
          if (bus_valid && bus_ready && bus_last) state_d = ST_REL;
        end
      end
      ST_REL: begin
        // Wait for the arbiter to drop the grant before requesting again.
        if (!gnt) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, forced-burst flag, sticky error and packet counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      forced_q  <= 1'b0;
      err_q     <= 1'b0;
      pkt_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      forced_q  <= forced_d;
      err_q     <= err_d;
      pkt_cnt_q <= pkt_cnt_d;
    end
  end

endmodule

// File: tb/tb_bus_requester.sv
// Randomised and directed bench for bus_requester. A queue scoreboard holds
// every accepted beat; bus beats must match its head, and bus_last must be
// the stored flag or the final beat of a burst that started with no complete
// packet queued. A registered arbiter model grants one cycle after req.
module tb_bus_requester;

  localparam int DW    = 8;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_valid;
  logic          wr_ready;
  logic [DW-1:0] wr_data;
  logic          wr_last;
  logic          req;
  logic          gnt;
  logic          bus_valid;
  logic [DW-1:0] bus_data;
  logic          bus_last;
  logic          bus_ready;
  logic          err;
  logic          kill;
  bit            kill_on_first;

  bus_requester #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_data   (wr_data),
    .wr_last   (wr_last),
    .req       (req),
    .gnt       (gnt),
    .bus_valid (bus_valid),
    .bus_data  (bus_data),
    .bus_last  (bus_last),
    .bus_ready (bus_ready),
    .err       (err)
  );

  always #5 clk = ~clk;

  // Registered single-input arbiter; kill forces the grant away.
  always @(posedge clk or negedge rst) begin
    if (!rst) gnt <= 1'b0;
    else      gnt <= req & ~kill;
  end

  logic [DW:0] q[$];
  logic [DW:0] wq[$];
  bit forced_m, prev_req, pushed, saw_full;
  int cyc, n_pops, t_req, t_val, t_lastwr, t_pop1, t_popn;
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int lasts_in_q();
    int n = 0;
    foreach (q[i]) if (q[i][DW]) n++;
    return n;
  endfunction

  // One clock: sample and check at negedge+1, then apply transfers to model.
  task automatic cycle();
    logic [DW:0] hd;
    logic [DW:0] wword;
    bit do_push, do_pop, exp_last;
    #1;
    if (req && t_req < 0) t_req = cyc;
    if (bus_valid && t_val < 0) t_val = cyc;
    if (req && !prev_req) forced_m = (lasts_in_q() == 0);
    prev_req = req;
    if (!wr_ready) saw_full = 1;
    check_eq("wr_ready", 32'(wr_ready), 32'(q.size() < DEPTH));
    if (bus_valid) begin
      check_eq("valid_has_grant", 32'(gnt & req), 32'(1));
      check_eq("beat_available", 32'(q.size() != 0), 32'(1));
      if (q.size() != 0) begin
        hd = q[0];
        exp_last = hd[DW] | (forced_m && q.size() == 1);
        check_eq("bus_data", 32'(bus_data), 32'(hd[DW-1:0]));
        check_eq("bus_last", 32'(bus_last), 32'(exp_last));
      end
    end
    do_push = wr_valid && wr_ready;
    do_pop  = bus_valid && bus_ready;
    wword   = {wr_last, wr_data};
    if (do_push) $display("[%0t] write data=%02h last=%0b", $time, wr_data, wr_last);
    if (do_pop) begin
      $display("[%0t] bus beat data=%02h last=%0b", $time, bus_data, bus_last);
      if (kill_on_first) begin
        kill = 1'b1;
        kill_on_first = 0;
      end
    end
    @(posedge clk);
    cyc++;
    if (do_pop) begin
      void'(q.pop_front());
      n_pops++;
      if (n_pops == 1) t_pop1 = cyc;
      t_popn = cyc;
    end
    if (do_push) begin
      q.push_back(wword);
      if (wword[DW]) t_lastwr = cyc;
    end
    pushed = do_push;
    @(negedge clk);
  endtask

  // mwr: 0 write whenever possible, 1 random gaps.
  // mrdy: 0 ready=1, 1 toggle 1,0,..., 2 random, 3 ready=0.
  task automatic step(input int mwr, input int mrdy, input int i);
    bit v;
    v = (wq.size() != 0) && (mwr == 0 || $urandom_range(0, 3) != 0);
    wr_valid = v;
    if (v) begin
      wr_data = wq[0][DW-1:0];
      wr_last = wq[0][DW];
    end else begin
      wr_data = DW'($urandom);
      wr_last = 1'b0;
    end
    case (mrdy)
      0:       bus_ready = 1'b1;
      1:       bus_ready = (i % 2 == 0);
      2:       bus_ready = ($urandom_range(0, 2) != 0);
      default: bus_ready = 1'b0;
    endcase
    cycle();
    if (pushed) void'(wq.pop_front());
  endtask

  task automatic run(input int n, input int mwr, input int mrdy);
    for (int i = 0; i < n; i++) step(mwr, mrdy, i);
  endtask

  task automatic drain(input int max, input int mwr, input int mrdy);
    int i = 0;
    while ((q.size() != 0 || wq.size() != 0) && i < max) begin
      step(mwr, mrdy, i);
      i++;
    end
    check_eq("drain_complete", 32'(q.size() + wq.size()), 32'(0));
  endtask

  task automatic start_test();
    n_pops = 0; t_req = -1; t_val = -1; t_pop1 = -1; t_popn = -1;
    t_lastwr = -1; saw_full = 0;
  endtask

  task automatic load_abc();
    wq.push_back(9'h011);
    wq.push_back(9'h022);
    wq.push_back(9'h133);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int len;
    rst = 1'b0; wr_valid = 1'b0; wr_data = '0; wr_last = 1'b0;
    bus_ready = 1'b0; kill = 1'b0; kill_on_first = 0;
    cyc = 0; prev_req = 0; forced_m = 0;
    @(negedge clk); @(negedge clk);
    #1;
    check_eq("rst_req", 32'(req), 32'(0));
    check_eq("rst_bus_valid", 32'(bus_valid), 32'(0));
    check_eq("rst_bus_last", 32'(bus_last), 32'(0));
    check_eq("rst_wr_ready", 32'(wr_ready), 32'(1));
    check_eq("rst_err", 32'(err), 32'(0));
    @(negedge clk);
    rst = 1'b1;

    // Basic 3-beat packet, full-rate bus.
    start_test(); load_abc();
    drain(40, 0, 0);
    check_eq("t1_req_drop", 32'(req), 32'(0));
    check_eq("t1_req_latency", 32'(t_req - t_lastwr), 32'(1));
    check_eq("t1_valid_latency", 32'(t_val - t_lastwr), 32'(3));
    check_eq("t1_consecutive", 32'(t_popn - t_pop1), 32'(2));
    check_eq("t1_pops", 32'(n_pops), 32'(3));
    run(4, 0, 0);

    // Same packet with bus_ready toggling.
    start_test(); load_abc();
    drain(60, 0, 1);
    check_eq("t2_pops", 32'(n_pops), 32'(3));
    run(4, 0, 0);

    // Four beats, no last: FIFO fills and forces a burst.
    start_test();
    for (int k = 1; k <= 4; k++) wq.push_back({1'b0, 8'hA0 + 8'(k)});
    drain(40, 0, 0);
    check_eq("t3_full_seen", 32'(saw_full), 32'(1));
    check_eq("t3_pops", 32'(n_pops), 32'(4));
    check_eq("t3_err", 32'(err), 32'(0));
    run(4, 0, 0);

    // Grant lost after first beat.
    start_test(); load_abc();
    kill_on_first = 1;
    for (int k = 0; k < 40; k++) begin
      step(0, 0, k);
      if (err) break;
    end
    check_eq("t4_err_set", 32'(err), 32'(1));
    check_eq("t4_req_rel", 32'(req), 32'(0));
    check_eq("t4_pops_before", 32'(n_pops), 32'(1));
    run(4, 0, 0);
    check_eq("t4_rerequest", 32'(req), 32'(1));
    check_eq("t4_err_sticky", 32'(err), 32'(1));
    kill = 1'b0; n_pops = 0;
    drain(40, 0, 0);
    check_eq("t4_pops_after", 32'(n_pops), 32'(2));
    check_eq("t4_err_sticky2", 32'(err), 32'(1));
    run(4, 0, 0);

    // Asynchronous reset during XFER.
    start_test(); load_abc();
    for (int k = 0; k < 40; k++) begin
      step(0, 3, k);
      if (bus_valid) break;
    end
    check_eq("t5_in_xfer", 32'(bus_valid), 32'(1));
    rst = 1'b0;
    #1;
    check_eq("t5_req", 32'(req), 32'(0));
    check_eq("t5_bus_valid", 32'(bus_valid), 32'(0));
    check_eq("t5_wr_ready", 32'(wr_ready), 32'(1));
    check_eq("t5_err", 32'(err), 32'(0));
    q.delete(); wq.delete();
    @(posedge clk); @(negedge clk);
    rst = 1'b1; prev_req = 0; n_pops = 0;
    run(12, 0, 0);
    check_eq("t5_no_beats", 32'(n_pops), 32'(0));
    check_eq("t5_req_idle", 32'(req), 32'(0));

    // Random packets (1..6 beats), random gaps and back-pressure.
    start_test();
    for (int c = 0; c < 500; c++) begin
      if (wq.size() < 2) begin
        len = $urandom_range(1, 6);
        for (int b = 0; b < len; b++) wq.push_back({1'(b == len - 1), 8'($urandom)});
      end
      step(1, 2, c);
    end
    drain(400, 1, 2);
    check_eq("t6_err", 32'(err), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
